seg7_decoder: RTL and testbench
===============================

# seg7_decoder

Registered 4-bit-to-seven-segment decoder driving one active-low HEX display digit. Consumers such as the score counters feed the current digit value (0–9) on `bcd` every cycle; the block drives the segment lines one clock later. It has one output register stage, a blanking control and a compile-time option for hexadecimal glyphs.

## Interface
- `ACTIVE_LOW`, default 1: 1 means a lit segment is driven 0, matching the board HEX displays; 0 inverts all `leds` bits.
- Clock and reset (already decided): reset `reset`, synchronous, active-high; clock `clk`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; blanks the display.
- `bcd`  in  4  digit value to display.
- `blank`  in  1  1 means all segments are off on the next cycle, regardless of `bcd`.
- `leds`  out  7  segment drive; bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g (g is MSB).

## Operation
- Glyph map, shown as ACTIVE_LOW=1 values of `leds[6:0]`:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19
  - 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10
- Values 10–15 depend on the `SEG7_HEX_EN` macro (see Configuration).
- Blank pattern is all segments off: 7'h7F with ACTIVE_LOW=1, 7'h00 with ACTIVE_LOW=0.
- Priority, highest first: `reset`, then `blank`, then the decode of `bcd`.
- ACTIVE_LOW=0 applies a bitwise inversion of the whole pattern, blank included, after the glyph lookup.
- There is no other internal state.

## Timing
- `leds` is a register. `bcd` and `blank` sampled at edge N appear on `leds` after edge N, so latency is 1 cycle.
- Throughput: a new value is accepted every cycle; no handshake.
- Reset: `leds` holds the blank pattern from the first edge with `reset`=1 until the first edge after `reset` deasserts.
- Reset asserted mid-stream takes effect at the next edge, overriding any `bcd` value.
- Simultaneous `blank`=1 and a `bcd` change: output is blank; the new digit appears one cycle after `blank` drops.
- `leds` is X-free after the first reset edge. `bcd`=X is not required to be handled.

## Configuration
- Macro `SEG7_HEX_EN`.
- Defined: 10–15 show the hex glyphs A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Undefined: 10–15 produce the blank pattern, since those codes are illegal BCD.
- Digits 0–9, reset and blank behaviour are identical in both builds.

## Structure
- Package `seg7_pkg` holds:
  - the 7-bit segment typedef;
  - the glyph constants for 0–9 and A–F (active-low form);
  - the `SEG_BLANK` constant.
- Sub-module `seg7_lut`: purely combinational `bcd`→pattern lookup containing the `SEG7_HEX_EN` conditional.
- Top level `seg7_decoder` contains the blank/reset priority mux, the ACTIVE_LOW inversion and the output register.

## Test plan
- Reset: `reset`=1 for 2 cycles with `bcd`=8 → `leds`=7'h7F throughout. Release with `bcd`=8 → `leds`=7'h00 one cycle later.
- Sweep: `bcd`=0..9, one per cycle → `leds` follows 7'h40, 79, 24, 30, 19, 12, 02, 78, 00, 10, each lagging its `bcd` value by exactly 1 cycle.
- Illegal codes: `bcd`=10..15.
  - Without `SEG7_HEX_EN` → 7'h7F each.
  - With the macro → 7'h08, 03, 46, 21, 06, 0E.
- Blank priority: `bcd`=3 with `blank`=1 → 7'h7F. Drop `blank` → 7'h30 next cycle.
- Mid-run reset: `bcd` counting 0..9, assert `reset` at `bcd`=5 → next `leds`=7'h7F. After release, decode resumes with 1-cycle latency.
- Polarity: ACTIVE_LOW=0 with `bcd`=1 → 7'h06; after reset → 7'h00.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment type and glyph constants for the seven-segment decoder.
// All glyphs are stored in active-low form (a lit segment is 0).
// Bit order: bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Decimal digits
    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;

    // Hexadecimal letters A, b, C, d, E, F
    localparam seg_t SEG_A = 7'h08;
    localparam seg_t SEG_B = 7'h03;
    localparam seg_t SEG_C = 7'h46;
    localparam seg_t SEG_D = 7'h21;
    localparam seg_t SEG_E = 7'h06;
    localparam seg_t SEG_F = 7'h0E;

    // Every segment off
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_lut.sv
// Combinational 4-bit code to active-low segment pattern lookup.
// Compile-time option: define SEG7_HEX_EN to show A-F for codes 10-15;
// without it those codes (illegal BCD) produce the blank pattern.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       pattern_o
);

    // Glyph table; anything not listed falls back to blank
    always_comb begin
        pattern_o = SEG_BLANK;
        case (bcd_i)
            4'd0:  pattern_o = SEG_0;
            4'd1:  pattern_o = SEG_1;
            4'd2:  pattern_o = SEG_2;
            4'd3:  pattern_o = SEG_3;
            4'd4:  pattern_o = SEG_4;
            4'd5:  pattern_o = SEG_5;
            4'd6:  pattern_o = SEG_6;
            4'd7:  pattern_o = SEG_7;
            4'd8:  pattern_o = SEG_8;
            4'd9:  pattern_o = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10: pattern_o = SEG_A;
            4'd11: pattern_o = SEG_B;
            4'd12: pattern_o = SEG_C;
            4'd13: pattern_o = SEG_D;
            4'd14: pattern_o = SEG_E;
            4'd15: pattern_o = SEG_F;
`else
            default: pattern_o = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/seg7_decoder.sv
// Registered 4-bit to seven-segment decoder for one HEX display digit.
// Output appears one clock after bcd/blank are sampled.
// Priority: reset, then blank, then the glyph decode.
// ACTIVE_LOW=0 inverts the final pattern, blank included.
// Compile-time option: SEG7_HEX_EN (hex glyphs for 10-15, see seg7_lut).
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] leds
);

    seg_t glyph;
    seg_t pattern;
    seg_t leds_d;
    seg_t leds_q;

    seg7_lut u_lut (
        .bcd_i     (bcd),
        .pattern_o (glyph)
    );

    // Pick blank or glyph, then apply board polarity
    always_comb begin
        pattern = blank ? SEG_BLANK : glyph;
        leds_d  = ACTIVE_LOW ? pattern : ~pattern;
    end

    // Output register; reset forces the blank pattern in the board polarity
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q <= ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder. Two instances (ACTIVE_LOW=1 and 0)
// share the same stimulus; expected values are queued when inputs are
// driven and popped after the following rising edge.
module tb_seg7_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] bcd;
    logic       blank;
    logic [6:0] ledsLow;
    logic [6:0] ledsHigh;

    logic [6:0] expLowQ[$];
    logic [6:0] expHighQ[$];
    string      tagQ[$];

    int testCount;
    int failCount;

    seg7_decoder #(.ACTIVE_LOW(1'b1)) dutLow (
        .clk   (clk),
        .reset (reset),
        .bcd   (bcd),
        .blank (blank),
        .leds  (ledsLow)
    );

    seg7_decoder #(.ACTIVE_LOW(1'b0)) dutHigh (
        .clk   (clk),
        .reset (reset),
        .bcd   (bcd),
        .blank (blank),
        .leds  (ledsHigh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph table in active-low form
    function automatic logic [6:0] refGlyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:  g = 7'h40;
            4'd1:  g = 7'h79;
            4'd2:  g = 7'h24;
            4'd3:  g = 7'h30;
            4'd4:  g = 7'h19;
            4'd5:  g = 7'h12;
            4'd6:  g = 7'h02;
            4'd7:  g = 7'h78;
            4'd8:  g = 7'h00;
            4'd9:  g = 7'h10;
`ifdef SEG7_HEX_EN
            4'd10: g = 7'h08;
            4'd11: g = 7'h03;
            4'd12: g = 7'h46;
            4'd13: g = 7'h21;
            4'd14: g = 7'h06;
            4'd15: g = 7'h0E;
`endif
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Drive inputs away from the edge and queue what should appear after it
    task automatic applyStimulus(input logic [3:0] b, input logic bl,
                                 input logic rst, input string tag);
        logic [6:0] e;
        @(negedge clk);
        bcd   = b;
        blank = bl;
        reset = rst;
        e = (rst || bl) ? 7'h7F : refGlyph(b);
        expLowQ.push_back(e);
        expHighQ.push_back(~e);
        tagQ.push_back(tag);
    endtask

    // Wait past the edge, pop the oldest expectation and compare both DUTs
    task automatic checkOutput();
        logic [6:0] eLow;
        logic [6:0] eHigh;
        string      tag;
        @(posedge clk);
        #1;
        eLow  = expLowQ.pop_front();
        eHigh = expHighQ.pop_front();
        tag   = tagQ.pop_front();
        testCount++;
        assert (ledsLow === eLow) else begin
            failCount++;
            $error("[TB] FAIL %s (active-low): got %h expected %h", tag, ledsLow, eLow);
        end
        testCount++;
        assert (ledsHigh === eHigh) else begin
            failCount++;
            $error("[TB] FAIL %s (active-high): got %h expected %h", tag, ledsHigh, eHigh);
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        reset = 1'b1;
        blank = 1'b0;
        bcd   = 4'd8;

        // Reset held two cycles with bcd=8, then release
        applyStimulus(4'd8, 1'b0, 1'b1, "reset0");   checkOutput();
        applyStimulus(4'd8, 1'b0, 1'b1, "reset1");   checkOutput();
        applyStimulus(4'd8, 1'b0, 1'b0, "release8"); checkOutput();

        // Decimal sweep, back-to-back
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'(i), 1'b0, 1'b0, $sformatf("sweep%0d", i));
            checkOutput();
        end

        // Codes 10..15 (blank or hex depending on build)
        for (int i = 10; i < 16; i++) begin
            applyStimulus(4'(i), 1'b0, 1'b0, $sformatf("code%0d", i));
            checkOutput();
        end

        // Blank priority over a digit change, then blank drops
        applyStimulus(4'd7, 1'b0, 1'b0, "preBlank");  checkOutput();
        applyStimulus(4'd3, 1'b1, 1'b0, "blank3");    checkOutput();
        applyStimulus(4'd3, 1'b0, 1'b0, "unblank3");  checkOutput();

        // Blank together with an illegal code and with reset
        applyStimulus(4'd15, 1'b1, 1'b0, "blank15");  checkOutput();
        applyStimulus(4'd1, 1'b1, 1'b1, "blankRst");  checkOutput();

        // Counting stream with a reset at bcd=5
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'(i), 1'b0, (i == 5), $sformatf("midrun%0d", i));
            checkOutput();
        end

        // Polarity spot check: bcd=1 then reset
        applyStimulus(4'd1, 1'b0, 1'b0, "polarity1");   checkOutput();
        applyStimulus(4'd1, 1'b0, 1'b1, "polarityRst"); checkOutput();
        applyStimulus(4'd1, 1'b0, 1'b0, "polarityRel"); checkOutput();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
